// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: host byte handshake (start/data/ready/done) and the serial tx line.
interface uart_transmitter_if;
  logic start;
  logic [7:0] data;
  logic tx;
  logic ready;
  logic done;
  modport master (output start, data, input tx, ready, done);
  modport slave (input start, data, output tx, ready, done);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 LSB-first UART transmitter, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1041,
  parameter int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input logic clk,
  input logic reset,
  uart_transmitter_if.slave bus
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0] idx, idx_d;
  logic [7:0] sh, sh_d;
  logic tx, tx_d, done, done_d, expire;
`ifdef UART_TX_PARITY_EN
  logic par, par_d;
`endif
  assign expire = cnt == LAST;
  assign bus.tx = tx;
  assign bus.ready = state == IDLE;
  assign bus.done = done;
  // tx is registered from its next value so the line never glitches between bits
  always_comb begin
    state_d = state;
    cnt_d = (state == IDLE || expire) ? '0 : cnt + 1'b1;
    idx_d = idx;
    sh_d = sh;
    tx_d = tx;
    done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d = par;
`endif
    case (state)
      IDLE: if (bus.start) begin
        state_d = START;
        sh_d = bus.data;
        idx_d = '0;
        tx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d = ^bus.data;
`endif
      end
      START: if (expire) begin
        state_d = DATA;
        tx_d = sh[0];
      end
      DATA: if (expire) begin
        idx_d = idx + 1'b1;
        sh_d = sh >> 1;
`ifdef UART_TX_PARITY_EN
        state_d = idx == 3'd7 ? PARITY : DATA;
        tx_d = idx == 3'd7 ? par : sh[1];
`else
        state_d = idx == 3'd7 ? STOP : DATA;
        tx_d = idx == 3'd7 ? 1'b1 : sh[1];
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (expire) begin
        state_d = STOP;
        tx_d = 1'b1;
      end
`endif
      STOP: if (expire) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      sh <= sh_d;
      tx <= tx_d;
      done <= done_d;
`ifdef UART_TX_PARITY_EN
      par <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed and random frames checked against a bit-slot model of the UART frame.
module tb_uart_transmitter;
  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  uart_transmitter_if bus ();
  uart_transmitter #(.CLKS_PER_BIT(C)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected line level in bit slot k of a frame carrying d
  function automatic logic model_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && F == 11) return ^d;
    return 1'b1;
  endfunction

  task automatic idle_check(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.ready !== 1'b1 || bus.done !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic accept(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", {31'b0, bus.ready}, 1);
    bus.start = 1'b1;
    bus.data = d;
    @(posedge clk);
  endtask

  // runs from the accept edge through the done cycle, decoding tx at bit centres
  task automatic frame(input logic [7:0] d, input bit keep, input bit repulse, input int abort_at, input string tag);
    logic [7:0] rx = '0;
    int low = 0;
    int dones = 0;
    int done_at = -1;
    for (int j = 0; j <= F * C; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check({tag, " start_edge"}, {31'b0, bus.tx}, 0);
        if (!keep) bus.start = 1'b0;
      end
      if (!keep && j == 20) bus.data = 8'($urandom);
      if (repulse && j == 40) bus.start = 1'b1;
      if (repulse && j == 41) bus.start = 1'b0;
      if (j == abort_at) begin
        reset = 1'b0;
        #1;
        check({tag, " abort_tx"}, {31'b0, bus.tx}, 1);
        check({tag, " abort_ready"}, {31'b0, bus.ready}, 1);
        check({tag, " abort_done"}, {31'b0, bus.done}, 0);
        return;
      end
      if (j % C == C / 2) begin
        check($sformatf("%s bit%0d", tag, j / C), {31'b0, bus.tx}, {31'b0, model_bit(d, j / C)});
        if (j / C >= 1 && j / C <= 8) rx[j / C - 1] = bus.tx;
      end
      if (bus.ready !== 1'b1) low++;
      if (bus.done === 1'b1) begin
        dones++;
        done_at = j;
      end
    end
    check({tag, " ready_low"}, low, F * C);
    check({tag, " done_count"}, dones, 1);
    check({tag, " done_at"}, done_at, F * C);
    check({tag, " loopback"}, {24'b0, rx}, {24'b0, d});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, bus.tx}, 1);
    check("reset_ready", {31'b0, bus.ready}, 1);
    check("reset_done", {31'b0, bus.done}, 0);
    reset = 1'b1;
    idle_check(50, "idle50");
    accept(8'hA5);
    frame(8'hA5, 1'b0, 1'b0, -1, "a5");
    accept(8'h3C);
    frame(8'h3C, 1'b1, 1'b0, -1, "3c_first");
    @(posedge clk);
    frame(8'h3C, 1'b0, 1'b0, -1, "3c_second");
    accept(8'hFF);
    frame(8'hFF, 1'b0, 1'b1, -1, "ff_repulse");
    idle_check(3 * C, "ff_not_queued");
    accept(8'h00);
    frame(8'h00, 1'b0, 1'b0, 70, "00_abort");
    repeat (2) @(negedge clk);
    check("in_reset_tx", {31'b0, bus.tx}, 1);
    reset = 1'b1;
    idle_check(5, "post_reset_idle");
    accept(8'h81);
    frame(8'h81, 1'b0, 1'b0, -1, "81");
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      accept(d);
      frame(d, 1'b0, 1'b0, -1, $sformatf("rand%0d_%02h", i, d));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
